seven_sd_digit_loader: RTL and testbench

//  Parametrised successor to the fixed 4-button seven-segment value setter. One button channel
//  per display digit: each channel synchronises, debounces and optionally auto-repeats its

---
 rtl/seven_sd_digit_loader.sv | 111 +++++++++++
 tb/tb_seven_sd_digit_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seven_sd_digit_loader.sv
// seven_sd_digit_loader: per-digit button channels editing a packed multi-digit display value
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn          : raw active-high buttons, bit i edits digit i
//   data_in      : value written by a load edit
//   mode         : 00 load, 01 inc, 10 dec, 11 clear
//   value_out    : digit i at [i*DIG_W +: DIG_W]
//   btn_state    : debounced level per channel
//   event_pulse  : one-cycle strobe per applied edit per channel
module seven_sd_digit_loader #(
    parameter int NUM_DIGITS      = 4,
    parameter int DIG_W           = 8,
    parameter int DEBOUNCE_CYCLES = 25000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS-1:0]       btn,
    input  logic [DIG_W-1:0]            data_in,
    input  logic [1:0]                  mode,
    output logic [NUM_DIGITS*DIG_W-1:0] value_out,
    output logic [NUM_DIGITS-1:0]       btn_state,
    output logic [NUM_DIGITS-1:0]       event_pulse
);
    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW = $clog2(MAX_P + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, LOCK_P, HELD, RPT, LOCK_R} stateT;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : gChan
        logic [1:0]       syncQ;
        stateT            state, stateNext;
        logic [CW-1:0]    cnt, cntNext;
        logic             held, heldNext, fire, pulse;
        logic [DIG_W-1:0] digit, digitNext;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                syncQ <= '0;
                state <= IDLE;
                cnt   <= '0;
                held  <= 1'b0;
                pulse <= 1'b0;
                digit <= '0;
            end else begin
                syncQ <= {syncQ[0], btn[i]};
                state <= stateNext;
                cnt   <= cntNext;
                held  <= heldNext;
                pulse <= fire;
                digit <= digitNext;
            end
        end

        // cnt runs from press acceptance through LOCK_P into HELD, so the first
        // repeat is timed from the press, not from the end of the lockout.
        always_comb begin
            stateNext = state;
            cntNext   = cnt + 1'b1;
            heldNext  = held;
            fire      = 1'b0;
            case (state)
                IDLE: begin
                    cntNext = '0;
                    if (syncQ[1]) begin
                        fire      = 1'b1;
                        heldNext  = 1'b1;
                        stateNext = LOCK_P;
                    end
                end
                LOCK_P: if (cnt == DEB_LAST) stateNext = HELD;
                HELD: begin
                    if (!syncQ[1]) begin
                        heldNext  = 1'b0;
                        cntNext   = '0;
                        stateNext = LOCK_R;
                    end else if (REPEAT_EN != 0 && cnt == DLY_LAST) begin
                        fire      = 1'b1;
                        cntNext   = '0;
                        stateNext = RPT;
                    end
                end
                RPT: begin
                    if (!syncQ[1]) begin
                        heldNext  = 1'b0;
                        cntNext   = '0;
                        stateNext = LOCK_R;
                    end else if (cnt == PER_LAST) begin
                        fire    = 1'b1;
                        cntNext = '0;
                    end
                end
                LOCK_R: if (cnt == DEB_LAST) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
            digitNext = !fire ? digit :
                        (mode == 2'b00) ? data_in :
                        (mode == 2'b01) ? digit + DIG_W'(1) :
                        (mode == 2'b10) ? digit - DIG_W'(1) : '0;
        end

        assign value_out[i*DIG_W +: DIG_W] = digit;
        assign btn_state[i]   = held;
        assign event_pulse[i] = pulse;
    end
endmodule

// File: tb/tb_seven_sd_digit_loader.sv
// tb_seven_sd_digit_loader: directed self-checking bench for seven_sd_digit_loader
module tb_seven_sd_digit_loader;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  btn = '0, btnB = '0;
    logic [7:0]  data_in = '0;
    logic [1:0]  mode = '0;
    logic [31:0] value_out, valueB;
    logic [3:0]  btn_state, event_pulse, stateB, pulseB;
    int total = 0, bad = 0, cyc = 0, pulseCntB1 = 0;
    int pulseCnt[4] = '{0, 0, 0, 0};
    int evt1[$];

    seven_sd_digit_loader #(.NUM_DIGITS(4), .DIG_W(8), .DEBOUNCE_CYCLES(8), .REPEAT_EN(1),
                            .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .data_in(data_in), .mode(mode),
        .value_out(value_out), .btn_state(btn_state), .event_pulse(event_pulse));

    seven_sd_digit_loader #(.NUM_DIGITS(4), .DIG_W(8), .DEBOUNCE_CYCLES(8), .REPEAT_EN(0),
                            .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dutB (
        .clk(clk), .rst_n(rst_n), .btn(btnB), .data_in(data_in), .mode(mode),
        .value_out(valueB), .btn_state(stateB), .event_pulse(pulseB));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (event_pulse[i]) pulseCnt[i] <= pulseCnt[i] + 1;
        if (event_pulse[1]) evt1.push_back(cyc);
        if (pulseB[1]) pulseCntB1 <= pulseCntB1 + 1;
    end

    task automatic waitN(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m, input logic [3:0] mB, input int hold, input int settle);
        btn = m;
        btnB = mB;
        waitN(hold);
        btn = '0;
        btnB = '0;
        waitN(settle);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; btn = 4'hF; data_in = 8'h5A; mode = 2'b00;
        waitN(3);
        total++; if (value_out !== 32'h0) begin bad++; $display("FAIL reset_value got=%h want=%h", value_out, 32'h0); end
        total++; if (event_pulse !== 4'h0) begin bad++; $display("FAIL reset_pulse got=%h want=%h", event_pulse, 4'h0); end
        total++; if (btn_state !== 4'h0) begin bad++; $display("FAIL reset_state got=%h want=%h", btn_state, 4'h0); end
        rst_n = 1'b1;
        waitN(2);
        total++; if (event_pulse !== 4'h0 || value_out !== 32'h0) begin bad++; $display("FAIL reset_early got=%h/%h want=0/0", event_pulse, value_out); end
        waitN(1);
        total++; if (event_pulse !== 4'hF) begin bad++; $display("FAIL reset_press_pulse got=%h want=%h", event_pulse, 4'hF); end
        total++; if (value_out !== 32'h5A5A5A5A) begin bad++; $display("FAIL reset_press_value got=%h want=%h", value_out, 32'h5A5A5A5A); end
        total++; if (btn_state !== 4'hF) begin bad++; $display("FAIL reset_press_state got=%h want=%h", btn_state, 4'hF); end
        waitN(1);
        total++; if (event_pulse !== 4'h0) begin bad++; $display("FAIL reset_pulse_width got=%h want=%h", event_pulse, 4'h0); end
        btn = '0;
        waitN(30);
    endtask

    task automatic test_load;
        int b[4];
        mode = 2'b11;
        press(4'hF, 4'h0, 4, 30);
        total++; if (value_out !== 32'h0) begin bad++; $display("FAIL clear_all got=%h want=%h", value_out, 32'h0); end
        mode = 2'b00; data_in = 8'h3C;
        b = pulseCnt;
        press(4'b0100, 4'h0, 10, 30);
        total++; if (value_out !== 32'h003C_0000) begin bad++; $display("FAIL load_value got=%h want=%h", value_out, 32'h003C_0000); end
        total++; if (pulseCnt[2] - b[2] !== 1) begin bad++; $display("FAIL load_pulses got=%0d want=1", pulseCnt[2] - b[2]); end
        total++; if (pulseCnt[0] + pulseCnt[1] + pulseCnt[3] - b[0] - b[1] - b[3] !== 0) begin
            bad++; $display("FAIL load_other_pulses got=%0d want=0", pulseCnt[0] + pulseCnt[1] + pulseCnt[3] - b[0] - b[1] - b[3]); end
    endtask

    task automatic test_bounce;
        int b0;
        mode = 2'b01;
        b0 = pulseCnt[0];
        for (int c = 0; c < 12; c++) begin
            btn[0] = ((c / 2) % 2 == 0);
            waitN(1);
        end
        btn = '0;
        total++; if (btn_state[0] !== 1'b1) begin bad++; $display("FAIL bounce_state_locked got=%b want=1", btn_state[0]); end
        waitN(30);
        total++; if (btn_state[0] !== 1'b0) begin bad++; $display("FAIL bounce_state_final got=%b want=0", btn_state[0]); end
        total++; if (value_out[7:0] !== 8'h01) begin bad++; $display("FAIL bounce_value got=%h want=%h", value_out[7:0], 8'h01); end
        total++; if (pulseCnt[0] - b0 !== 1) begin bad++; $display("FAIL bounce_pulses got=%0d want=1", pulseCnt[0] - b0); end
    endtask

    task automatic test_repeat;
        int q0, bB;
        int expOff[5] = '{0, 20, 25, 30, 35};
        mode = 2'b00; data_in = 8'hFD;
        press(4'b0010, 4'b0010, 4, 30);
        mode = 2'b01;
        q0 = evt1.size();
        bB = pulseCntB1;
        press(4'b0010, 4'b0010, 40, 30);
        total++; if (evt1.size() - q0 !== 5) begin bad++; $display("FAIL repeat_count got=%0d want=5", evt1.size() - q0); end
        if (evt1.size() - q0 == 5)
            for (int j = 1; j < 5; j++) begin
                total++;
                if (evt1[q0 + j] - evt1[q0] !== expOff[j]) begin
                    bad++; $display("FAIL repeat_offset%0d got=%0d want=%0d", j, evt1[q0 + j] - evt1[q0], expOff[j]);
                end
            end
        total++; if (value_out[15:8] !== 8'h02) begin bad++; $display("FAIL repeat_wrap got=%h want=%h", value_out[15:8], 8'h02); end
        total++; if (valueB[15:8] !== 8'hFE) begin bad++; $display("FAIL norepeat_value got=%h want=%h", valueB[15:8], 8'hFE); end
        total++; if (pulseCntB1 - bB !== 1) begin bad++; $display("FAIL norepeat_pulses got=%0d want=1", pulseCntB1 - bB); end
    endtask

    task automatic test_simultaneous;
        mode = 2'b00;
        data_in = 8'hAA; press(4'b1000, 4'h0, 4, 30);
        data_in = 8'hBB; press(4'b0100, 4'h0, 4, 30);
        data_in = 8'hCC; press(4'b0010, 4'h0, 4, 30);
        data_in = 8'hDD; press(4'b0001, 4'h0, 4, 30);
        total++; if (value_out !== 32'hAABBCCDD) begin bad++; $display("FAIL simul_preload got=%h want=%h", value_out, 32'hAABBCCDD); end
        mode = 2'b11;
        btn = 4'b1001;
        waitN(2);
        total++; if (event_pulse !== 4'h0) begin bad++; $display("FAIL simul_early got=%b want=%b", event_pulse, 4'h0); end
        waitN(1);
        total++; if (event_pulse !== 4'b1001) begin bad++; $display("FAIL simul_pulse got=%b want=%b", event_pulse, 4'b1001); end
        total++; if (value_out !== 32'h00BBCC00) begin bad++; $display("FAIL simul_value got=%h want=%h", value_out, 32'h00BBCC00); end
        btn = '0;
        waitN(30);
    endtask

    task automatic test_midreset;
        int b;
        mode = 2'b01;
        btn = 4'b1000;
        waitN(24);
        total++; if (value_out[31:24] !== 8'h02) begin bad++; $display("FAIL midrst_pre got=%h want=%h", value_out[31:24], 8'h02); end
        rst_n = 1'b0;
        #1;
        total++; if (value_out !== 32'h0) begin bad++; $display("FAIL midrst_value got=%h want=%h", value_out, 32'h0); end
        total++; if (event_pulse !== 4'h0 || btn_state !== 4'h0) begin bad++; $display("FAIL midrst_flags got=%h/%h want=0/0", event_pulse, btn_state); end
        btn = '0;
        waitN(2);
        rst_n = 1'b1;
        b = pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3];
        waitN(30);
        total++; if (pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3] - b !== 0) begin
            bad++; $display("FAIL midrst_stray got=%0d want=0", pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3] - b); end
        total++; if (value_out !== 32'h0) begin bad++; $display("FAIL midrst_after got=%h want=%h", value_out, 32'h0); end
    endtask

    initial begin
        waitN(1);
        test_reset;
        test_load;
        test_bounce;
        test_repeat;
        test_simultaneous;
        test_midreset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
